// File: rtl/pfreq_pkg.sv
// Shared types and constants for the prefetch request scheduler.
package pfreq_pkg;

  localparam int PF_W_W      = 4;
  localparam int LADDR_W     = 32;
  localparam int SPTBR_W     = 16;
  localparam int PF_LINE_OFF = 6;
  localparam int LINE_W      = LADDR_W - PF_LINE_OFF;

  typedef logic [PF_W_W-1:0]  PF_weigth_type;
  typedef logic [LADDR_W-1:0] SC_laddr_type;
  typedef logic [SPTBR_W-1:0] SC_sptbr_type;
  typedef logic [LINE_W-1:0]  SC_line_type;

  typedef enum logic {
    TGT_DC = 1'b0,
    TGT_L2 = 1'b1
  } pfreq_target_t;

  typedef struct packed {
    PF_weigth_type w;
    SC_laddr_type  laddr;
    SC_sptbr_type  sptbr;
  } pfreq_req_t;

  // Cache-line number of a logical address (drops the in-line offset).
  function automatic SC_line_type line_of(input SC_laddr_type a);
    return a[LADDR_W-1:PF_LINE_OFF];
  endfunction

endpackage

// File: rtl/pfreq_fifo.sv
// Synchronous FIFO with registered full flag and single-cycle flush.
module pfreq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointer advance with explicit wrap so any depth works.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && (count_r != '0);
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = (count_r == '0);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and full flag; flush returns everything to empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
    end
  end

  // Entry storage; written only on an accepted push outside flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/pfreq_sched.sv
// Prefetch request scheduler: buffers requests, filters recent duplicate
// lines, and issues each survivor to a DC or L2 port chosen by weight on the
// pipe selected by line-address interleave.
module pfreq_sched
  import pfreq_pkg::*;
#(
  parameter int NPIPES     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int FILT_N     = 4,
  parameter int DC_THRESH  = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pfe_req_valid,
  output logic                        pfe_req_retry,
  input  PF_weigth_type               pfe_req_w,
  input  SC_laddr_type                pfe_req_laddr,
  input  SC_sptbr_type                pfe_req_sptbr,
  input  logic                        flush,
  output logic         [NPIPES-1:0]   pftodc_req_valid,
  input  logic         [NPIPES-1:0]   pftodc_req_retry,
  output SC_laddr_type [NPIPES-1:0]   pftodc_req_laddr,
  output SC_sptbr_type [NPIPES-1:0]   pftodc_req_sptbr,
  output logic         [NPIPES-1:0]   pftol2_req_valid,
  input  logic         [NPIPES-1:0]   pftol2_req_retry,
  output SC_laddr_type [NPIPES-1:0]   pftol2_req_laddr,
  output SC_sptbr_type [NPIPES-1:0]   pftol2_req_sptbr,
  output logic         [CNT_W-1:0]    stat_dc_sent,
  output logic         [CNT_W-1:0]    stat_l2_sent,
  output logic         [CNT_W-1:0]    stat_dropped
);

  localparam int PIPE_W = (NPIPES > 1) ? $clog2(NPIPES) : 1;
  localparam int FPTR_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  pfreq_req_t          enq_req_s;
  pfreq_req_t          head_s;
  logic [FCNT_W-1:0]   fifo_count_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                enq_s;
  logic                deq_s;
  logic                drop_s;
  logic                disp_s;
  logic                filt_hit_s;
  logic                slot_free_s;
  SC_line_type         head_line_s;
  pfreq_target_t       head_tgt_s;
  logic [PIPE_W-1:0]   head_pipe_s;
  logic [NPIPES-1:0]   dc_xfer_s;
  logic [NPIPES-1:0]   l2_xfer_s;
  logic [NPIPES-1:0]   dc_load_s;
  logic [NPIPES-1:0]   l2_load_s;

  logic [FILT_N-1:0]   filt_valid_r;
  SC_line_type         filt_line_r  [FILT_N];
  SC_sptbr_type        filt_sptbr_r [FILT_N];
  logic [FPTR_W-1:0]   filt_ptr_r;

  // Number of set bits, sized for the saturating adder.
  function automatic logic [CNT_W:0] ones(input logic [NPIPES-1:0] v);
    logic [CNT_W:0] n;
    n = '0;
    for (int i = 0; i < NPIPES; i++) begin
      n = n + (CNT_W + 1)'(v[i]);
    end
    return n;
  endfunction

  // Add and clamp at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + inc;
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  assign enq_req_s     = '{w: pfe_req_w, laddr: pfe_req_laddr, sptbr: pfe_req_sptbr};
  assign enq_s         = pfe_req_valid && !flush && (fifo_count_s != FCNT_W'(FIFO_DEPTH));
  assign pfe_req_retry = fifo_full_s;
  assign dc_xfer_s     = pftodc_req_valid & ~pftodc_req_retry;
  assign l2_xfer_s     = pftol2_req_valid & ~pftol2_req_retry;

  pfreq_fifo #(
    .WIDTH ($bits(pfreq_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (enq_s),
    .push_data (enq_req_s),
    .pop       (deq_s),
    .head_data (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Head decision: drop a filtered duplicate, dispatch into a free or
  // draining output slot, otherwise hold the head in place.
  always_comb begin
    deq_s       = 1'b0;
    drop_s      = 1'b0;
    disp_s      = 1'b0;
    filt_hit_s  = 1'b0;
    head_line_s = line_of(head_s.laddr);
    head_tgt_s  = (32'(head_s.w) >= 32'(DC_THRESH)) ? TGT_DC : TGT_L2;
    if (NPIPES == 1) begin
      head_pipe_s = '0;
    end else begin
      head_pipe_s = head_s.laddr[PF_LINE_OFF +: PIPE_W];
    end
    for (int i = 0; i < FILT_N; i++) begin
      if (filt_valid_r[i] && (filt_line_r[i] == head_line_s) &&
          (filt_sptbr_r[i] == head_s.sptbr)) begin
        filt_hit_s = 1'b1;
      end else begin
        filt_hit_s = filt_hit_s;
      end
    end
    if (head_tgt_s == TGT_DC) begin
      slot_free_s = !pftodc_req_valid[head_pipe_s] || dc_xfer_s[head_pipe_s];
    end else begin
      slot_free_s = !pftol2_req_valid[head_pipe_s] || l2_xfer_s[head_pipe_s];
    end
    if (!fifo_empty_s && !flush) begin
      if (filt_hit_s) begin
        deq_s  = 1'b1;
        drop_s = 1'b1;
      end else if (slot_free_s) begin
        deq_s  = 1'b1;
        disp_s = 1'b1;
      end else begin
        deq_s  = 1'b0;
      end
    end else begin
      deq_s = 1'b0;
    end
    dc_load_s = (disp_s && (head_tgt_s == TGT_DC)) ? (NPIPES'(1) << head_pipe_s) : '0;
    l2_load_s = (disp_s && (head_tgt_s == TGT_L2)) ? (NPIPES'(1) << head_pipe_s) : '0;
  end

  // Output slots: load on dispatch, clear on transfer, otherwise hold stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pftodc_req_valid <= '0;
      pftodc_req_laddr <= '0;
      pftodc_req_sptbr <= '0;
      pftol2_req_valid <= '0;
      pftol2_req_laddr <= '0;
      pftol2_req_sptbr <= '0;
    end else begin
      for (int i = 0; i < NPIPES; i++) begin
        if (dc_load_s[i]) begin
          pftodc_req_valid[i] <= 1'b1;
          pftodc_req_laddr[i] <= head_s.laddr;
          pftodc_req_sptbr[i] <= head_s.sptbr;
        end else if (dc_xfer_s[i]) begin
          pftodc_req_valid[i] <= 1'b0;
        end
        if (l2_load_s[i]) begin
          pftol2_req_valid[i] <= 1'b1;
          pftol2_req_laddr[i] <= head_s.laddr;
          pftol2_req_sptbr[i] <= head_s.sptbr;
        end else if (l2_xfer_s[i]) begin
          pftol2_req_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Recent-line filter: round-robin insert on dispatch, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_valid_r <= '0;
      filt_ptr_r   <= '0;
      for (int i = 0; i < FILT_N; i++) begin
        filt_line_r[i]  <= '0;
        filt_sptbr_r[i] <= '0;
      end
    end else if (flush) begin
      filt_valid_r <= '0;
      filt_ptr_r   <= '0;
    end else if (disp_s) begin
      filt_valid_r[filt_ptr_r] <= 1'b1;
      filt_line_r[filt_ptr_r]  <= head_line_s;
      filt_sptbr_r[filt_ptr_r] <= head_s.sptbr;
      if (filt_ptr_r == FPTR_W'(FILT_N - 1)) begin
        filt_ptr_r <= '0;
      end else begin
        filt_ptr_r <= filt_ptr_r + FPTR_W'(1);
      end
    end
  end

  // Saturating statistics; sent counters count transfers, not loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dc_sent <= '0;
      stat_l2_sent <= '0;
      stat_dropped <= '0;
    end else begin
      stat_dc_sent <= sat_add(stat_dc_sent, ones(dc_xfer_s));
      stat_l2_sent <= sat_add(stat_l2_sent, ones(l2_xfer_s));
      stat_dropped <= sat_add(stat_dropped, (CNT_W + 1)'(drop_s));
    end
  end

endmodule

// File: tb/tb_pfreq_sched.sv
// Testbench for pfreq_sched: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_pfreq_sched;
  import pfreq_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     pfe_req_valid;
  logic                     pfe_req_retry;
  PF_weigth_type            pfe_req_w;
  SC_laddr_type             pfe_req_laddr;
  SC_sptbr_type             pfe_req_sptbr;
  logic                     flush;
  logic         [1:0]       pftodc_req_valid;
  logic         [1:0]       pftodc_req_retry;
  SC_laddr_type [1:0]       pftodc_req_laddr;
  SC_sptbr_type [1:0]       pftodc_req_sptbr;
  logic         [1:0]       pftol2_req_valid;
  logic         [1:0]       pftol2_req_retry;
  SC_laddr_type [1:0]       pftol2_req_laddr;
  SC_sptbr_type [1:0]       pftol2_req_sptbr;
  logic         [15:0]      stat_dc_sent;
  logic         [15:0]      stat_l2_sent;
  logic         [15:0]      stat_dropped;

  int total = 0;
  int bad   = 0;

  pfreq_sched dut (
    .clk              (clk),
    .reset            (reset),
    .pfe_req_valid    (pfe_req_valid),
    .pfe_req_retry    (pfe_req_retry),
    .pfe_req_w        (pfe_req_w),
    .pfe_req_laddr    (pfe_req_laddr),
    .pfe_req_sptbr    (pfe_req_sptbr),
    .flush            (flush),
    .pftodc_req_valid (pftodc_req_valid),
    .pftodc_req_retry (pftodc_req_retry),
    .pftodc_req_laddr (pftodc_req_laddr),
    .pftodc_req_sptbr (pftodc_req_sptbr),
    .pftol2_req_valid (pftol2_req_valid),
    .pftol2_req_retry (pftol2_req_retry),
    .pftol2_req_laddr (pftol2_req_laddr),
    .pftol2_req_sptbr (pftol2_req_sptbr),
    .stat_dc_sent     (stat_dc_sent),
    .stat_l2_sent     (stat_l2_sent),
    .stat_dropped     (stat_dropped)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned  w;
    logic [31:0]  laddr;
    logic [15:0]  sptbr;
  } mreq_t;

  mreq_t        m_q[$];
  logic [41:0]  m_filt[$];
  logic [1:0]   m_dc_v, m_l2_v;
  logic [31:0]  m_dc_a[2], m_l2_a[2];
  logic [15:0]  m_dc_s[2], m_l2_s[2];
  int           m_dc_cnt, m_l2_cnt, m_drop;
  bit           m_full;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_filt.delete();
    m_dc_v = 2'b00;
    m_l2_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_dc_a[i] = '0; m_l2_a[i] = '0; m_dc_s[i] = '0; m_l2_s[i] = '0;
    end
    m_dc_cnt = 0; m_l2_cnt = 0; m_drop = 0;
    m_full = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit          acc, hit;
    logic [1:0]  dcx, l2x;
    mreq_t       h;
    logic [41:0] key;
    int          p;
    acc = pfe_req_valid && !m_full && !flush;
    dcx = m_dc_v & ~pftodc_req_retry;
    l2x = m_l2_v & ~pftol2_req_retry;
    m_dc_cnt = sat16(m_dc_cnt + $countones(dcx));
    m_l2_cnt = sat16(m_l2_cnt + $countones(l2x));
    m_dc_v = m_dc_v & ~dcx;
    m_l2_v = m_l2_v & ~l2x;
    if (flush) begin
      m_q.delete();
      m_filt.delete();
    end else if (m_q.size() > 0) begin
      h   = m_q[0];
      key = {h.laddr[31:6], h.sptbr};
      hit = 1'b0;
      foreach (m_filt[i]) if (m_filt[i] == key) hit = 1'b1;
      p = int'(h.laddr[6]);
      if (hit) begin
        void'(m_q.pop_front());
        m_drop = sat16(m_drop + 1);
      end else if (h.w >= 8 && !m_dc_v[p]) begin
        m_dc_v[p] = 1'b1; m_dc_a[p] = h.laddr; m_dc_s[p] = h.sptbr;
        void'(m_q.pop_front());
        m_filt.push_back(key);
      end else if (h.w < 8 && !m_l2_v[p]) begin
        m_l2_v[p] = 1'b1; m_l2_a[p] = h.laddr; m_l2_s[p] = h.sptbr;
        void'(m_q.pop_front());
        m_filt.push_back(key);
      end
      if (m_filt.size() > 4) void'(m_filt.pop_front());
    end
    if (acc) m_q.push_back('{w: int'(pfe_req_w), laddr: pfe_req_laddr, sptbr: pfe_req_sptbr});
    m_full = (m_q.size() == 4);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pfe_req_valid = 1'b0; pfe_req_w = '0; pfe_req_laddr = '0; pfe_req_sptbr = '0;
    flush = 1'b0; pftodc_req_retry = 2'b00; pftol2_req_retry = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic send(input int unsigned w, input logic [31:0] a, input logic [15:0] s);
    pfe_req_valid = 1'b1; pfe_req_w = PF_weigth_type'(w); pfe_req_laddr = a; pfe_req_sptbr = s;
    tick();
    pfe_req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({pftodc_req_valid, pftol2_req_valid, pfe_req_retry} !== 5'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", {pftodc_req_valid, pftol2_req_valid, pfe_req_retry});
    end
    total++;
    if ({stat_dc_sent, stat_l2_sent, stat_dropped} !== 48'h0) begin
      bad++; $display("FAIL reset_stats: got %h want 0", {stat_dc_sent, stat_l2_sent, stat_dropped});
    end
    total++;
    if ({pftodc_req_laddr, pftol2_req_laddr} !== 128'h0) begin
      bad++; $display("FAIL reset_laddr: got %h want 0", {pftodc_req_laddr, pftol2_req_laddr});
    end
  endtask

  task automatic test_dc_basic();
    do_reset();
    send(9, 32'h1000, 16'h0001);
    total++;
    if (pftodc_req_valid !== 2'b00) begin
      bad++; $display("FAIL dc_latency: valid at 1st edge got %b want 00", pftodc_req_valid);
    end
    tick();
    total++;
    if (pftodc_req_valid !== 2'b01 || pftodc_req_laddr[0] !== 32'h1000) begin
      bad++; $display("FAIL dc_issue: valid=%b laddr=%h want 01/00001000", pftodc_req_valid, pftodc_req_laddr[0]);
    end
    tick();
    total++;
    if (stat_dc_sent !== 16'd1 || pftodc_req_valid !== 2'b00) begin
      bad++; $display("FAIL dc_sent: stat=%0d valid=%b want 1/00", stat_dc_sent, pftodc_req_valid);
    end
  endtask

  task automatic test_l2_hold();
    do_reset();
    pftol2_req_retry = 2'b10;
    send(3, 32'h1040, 16'h0002);
    tick();
    total++;
    if (pftol2_req_valid !== 2'b10 || pftol2_req_laddr[1] !== 32'h1040) begin
      bad++; $display("FAIL l2_issue: valid=%b laddr=%h want 10/00001040", pftol2_req_valid, pftol2_req_laddr[1]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (pftol2_req_valid !== 2'b10 || pftol2_req_laddr[1] !== 32'h1040 || stat_l2_sent !== 16'd0) begin
        bad++; $display("FAIL l2_hold%0d: valid=%b laddr=%h stat=%0d want 10/00001040/0",
                        i, pftol2_req_valid, pftol2_req_laddr[1], stat_l2_sent);
      end
    end
    pftol2_req_retry = 2'b00;
    tick();
    repeat (3) tick();
    total++;
    if (stat_l2_sent !== 16'd1 || pftol2_req_valid !== 2'b00) begin
      bad++; $display("FAIL l2_sent_once: stat=%0d valid=%b want 1/00", stat_l2_sent, pftol2_req_valid);
    end
  endtask

  task automatic test_filter();
    logic [31:0] lines [5];
    lines = '{32'h3000, 32'h3080, 32'h3100, 32'h3180, 32'h3200};
    do_reset();
    send(9, 32'h2000, 16'h0001);
    send(9, 32'h2010, 16'h0001);
    repeat (3) tick();
    total++;
    if (stat_dc_sent !== 16'd1 || stat_dropped !== 16'd1) begin
      bad++; $display("FAIL filter_dup: sent=%0d dropped=%0d want 1/1", stat_dc_sent, stat_dropped);
    end
    for (int i = 0; i < 5; i++) send(9, lines[i], 16'h0001);
    send(9, 32'h2000, 16'h0001);
    repeat (4) tick();
    total++;
    if (stat_dc_sent !== 16'd7 || stat_dropped !== 16'd1) begin
      bad++; $display("FAIL filter_evict: sent=%0d dropped=%0d want 7/1", stat_dc_sent, stat_dropped);
    end
  endtask

  task automatic test_back_to_back();
    int          idx = 0;
    int          got = 0;
    logic [31:0] seen [6];
    do_reset();
    pftodc_req_retry = 2'b01;
    for (int c = 0; c < 30 && idx < 6 && !pfe_req_retry; c++) begin
      send(9, 32'h4000 + 32'(idx) * 32'h80, 16'h0003);
      idx++;
    end
    total++;
    if (pfe_req_retry !== 1'b1 || idx != 5) begin
      bad++; $display("FAIL bp_full: retry=%b accepted=%0d want 1/5", pfe_req_retry, idx);
    end
    pftodc_req_retry = 2'b00;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (pftodc_req_valid[0]) begin
        seen[got] = pftodc_req_laddr[0];
        got++;
      end
      if (idx < 6 && !pfe_req_retry) begin
        pfe_req_valid = 1'b1; pfe_req_w = 4'd9;
        pfe_req_laddr = 32'h4000 + 32'(idx) * 32'h80; pfe_req_sptbr = 16'h0003;
        idx++;
      end else begin
        pfe_req_valid = 1'b0;
      end
      tick();
    end
    pfe_req_valid = 1'b0;
    total++;
    if (got != 6) begin
      bad++; $display("FAIL bp_drain: issued=%0d want 6 within budget", got);
    end
    for (int k = 0; k < got; k++) begin
      total++;
      if (seen[k] !== 32'h4000 + 32'(k) * 32'h80) begin
        bad++; $display("FAIL bp_order%0d: got %h want %h", k, seen[k], 32'h4000 + 32'(k) * 32'h80);
      end
    end
    total++;
    if (stat_dc_sent !== 16'd6) begin
      bad++; $display("FAIL bp_stat: got %0d want 6", stat_dc_sent);
    end
  endtask

  task automatic test_flush();
    do_reset();
    pftodc_req_retry = 2'b01;
    send(9, 32'h5000, 16'h0004);
    send(9, 32'h5100, 16'h0004);
    send(9, 32'h5200, 16'h0004);
    send(9, 32'h5300, 16'h0004);
    flush = 1'b1;
    send(9, 32'h6000, 16'h0004);
    flush = 1'b0;
    total++;
    if (pftodc_req_valid !== 2'b01 || pftodc_req_laddr[0] !== 32'h5000 || pfe_req_retry !== 1'b0) begin
      bad++; $display("FAIL flush_pending: valid=%b laddr=%h retry=%b want 01/00005000/0",
                      pftodc_req_valid, pftodc_req_laddr[0], pfe_req_retry);
    end
    pftodc_req_retry = 2'b00;
    repeat (8) tick();
    total++;
    if (stat_dc_sent !== 16'd1 || stat_l2_sent !== 16'd0 || stat_dropped !== 16'd0 ||
        pftodc_req_valid !== 2'b00) begin
      bad++; $display("FAIL flush_stats: dc=%0d l2=%0d drop=%0d valid=%b want 1/0/0/00",
                      stat_dc_sent, stat_l2_sent, stat_dropped, pftodc_req_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      pfe_req_valid    = ($urandom_range(0, 9) < 6);
      pfe_req_w        = PF_weigth_type'($urandom_range(0, 15));
      pfe_req_laddr    = 32'h8000 | (32'($urandom_range(0, 7)) << 6) | 32'($urandom_range(0, 63));
      pfe_req_sptbr    = 16'($urandom_range(0, 1));
      flush            = ($urandom_range(0, 49) == 0);
      pftodc_req_retry = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
      pftol2_req_retry = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
      tick();
      total++;
      if ({pftodc_req_valid, pftol2_req_valid, pfe_req_retry} !== {m_dc_v, m_l2_v, m_full}) begin
        bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c,
                        {pftodc_req_valid, pftol2_req_valid, pfe_req_retry}, {m_dc_v, m_l2_v, m_full});
      end
      total++;
      if ({pftodc_req_laddr[1], pftodc_req_laddr[0], pftol2_req_laddr[1], pftol2_req_laddr[0],
           pftodc_req_sptbr[1], pftodc_req_sptbr[0], pftol2_req_sptbr[1], pftol2_req_sptbr[0]} !==
          {m_dc_a[1], m_dc_a[0], m_l2_a[1], m_l2_a[0], m_dc_s[1], m_dc_s[0], m_l2_s[1], m_l2_s[0]}) begin
        bad++; $display("FAIL rand_payload c=%0d: dc=%h/%h l2=%h/%h want dc=%h/%h l2=%h/%h", c,
                        pftodc_req_laddr[1], pftodc_req_laddr[0], pftol2_req_laddr[1], pftol2_req_laddr[0],
                        m_dc_a[1], m_dc_a[0], m_l2_a[1], m_l2_a[0]);
      end
      total++;
      if ({stat_dc_sent, stat_l2_sent, stat_dropped} !== {16'(m_dc_cnt), 16'(m_l2_cnt), 16'(m_drop)}) begin
        bad++; $display("FAIL rand_stats c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                        stat_dc_sent, stat_l2_sent, stat_dropped, m_dc_cnt, m_l2_cnt, m_drop);
      end
    end
    flush = 1'b0;
    pfe_req_valid = 1'b0;
  endtask

  task automatic test_saturate_and_async_reset();
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      pfe_req_valid = 1'b1; pfe_req_w = 4'd15;
      pfe_req_laddr = 32'(i) << 7; pfe_req_sptbr = 16'h0005;
      tick();
    end
    pfe_req_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (stat_dc_sent !== 16'hFFFF || m_dc_cnt != 65535) begin
      bad++; $display("FAIL sat_dc: got %h model %0d want FFFF", stat_dc_sent, m_dc_cnt);
    end
    pftodc_req_retry = 2'b01;
    send(9, 32'h7000, 16'h0006);
    tick();
    total++;
    if (pftodc_req_valid !== 2'b01 || stat_dc_sent !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold: valid=%b stat=%h want 01/FFFF", pftodc_req_valid, stat_dc_sent);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({pftodc_req_valid, pftol2_req_valid, pfe_req_retry} !== 5'b0 ||
        {stat_dc_sent, stat_l2_sent, stat_dropped} !== 48'h0 ||
        {pftodc_req_laddr, pftol2_req_laddr} !== 128'h0) begin
      bad++; $display("FAIL async_reset: valid=%b stats=%h laddr=%h want all 0",
                      {pftodc_req_valid, pftol2_req_valid, pfe_req_retry},
                      {stat_dc_sent, stat_l2_sent, stat_dropped}, pftodc_req_laddr[0]);
    end
    @(posedge clk);
    #1;
    pftodc_req_retry = 2'b00;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    test_reset();
    test_dc_basic();
    test_l2_hold();
    test_filter();
    test_back_to_back();
    test_flush();
    test_random();
    test_saturate_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
